// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a fixed-latency pipelined barrel shifter.
// Issues at most one request per cycle, tags it, and routes the result back to its owner.
module shift_arbiter #(
    parameter int LAT     = 5,
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_amt,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_amt,
    output logic        req1_ready,

    output logic        sh_valid,
    output logic [31:0] sh_data,
    output logic [4:0]  sh_amt,
    input  logic [31:0] sh_result,

    output logic        res0_valid,
    output logic [31:0] res0_data,
    output logic        res1_valid,
    output logic [31:0] res1_data,

    output logic        idle
);

    localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

    logic        ptr_q, ptr_d;
    logic [2:0]  cnt0_q, cnt0_d;
    logic [2:0]  cnt1_q, cnt1_d;

    // Bit 0 is the issue register; bits 1..LAT are the tag stages, bit LAT lines up with sh_result.
    logic [LAT:0] pipe_vld_q, pipe_vld_d;
    logic [LAT:0] pipe_tag_q, pipe_tag_d;

    logic [31:0] sh_data_q, sh_data_d;
    logic [4:0]  sh_amt_q, sh_amt_d;

    logic        res0_valid_q, res0_valid_d;
    logic [31:0] res0_data_q, res0_data_d;
    logic        res1_valid_q, res1_valid_d;
    logic [31:0] res1_data_q, res1_data_d;

    logic elig0, elig1;
    logic grant0, grant1;
    logic accept;
    logic tail_vld, tail_tag;

    // Arbitration: ready is purely a function of valid, credit and the priority pointer.
    always_comb begin
        elig0  = req0_valid && (cnt0_q < MAX_OUT_C);
        elig1  = req1_valid && (cnt1_q < MAX_OUT_C);
        grant0 = elig0 && (!elig1 || !ptr_q);
        grant1 = elig1 && (!elig0 || ptr_q);
        accept = grant0 || grant1;

        ptr_d = ptr_q;
        if (grant0) begin
            ptr_d = 1'b1;
        end else if (grant1) begin
            ptr_d = 1'b0;
        end
    end

    always_comb begin
        sh_data_d  = sh_data_q;
        sh_amt_d   = sh_amt_q;
        if (grant1) begin
            sh_data_d = req1_data;
            sh_amt_d  = req1_amt;
        end else if (grant0) begin
            sh_data_d = req0_data;
            sh_amt_d  = req0_amt;
        end
        pipe_vld_d = {pipe_vld_q[LAT-1:0], accept};
        pipe_tag_d = {pipe_tag_q[LAT-1:0], grant1};
    end

    assign tail_vld = pipe_vld_q[LAT];
    assign tail_tag = pipe_tag_q[LAT];

    always_comb begin
        res0_valid_d = tail_vld && !tail_tag;
        res1_valid_d = tail_vld && tail_tag;
        res0_data_d  = res0_valid_d ? sh_result : res0_data_q;
        res1_data_d  = res1_valid_d ? sh_result : res1_data_q;
    end

    // Credits return on the registered result pulse, so a freed slot is usable the next cycle.
    always_comb begin
        cnt0_d = cnt0_q;
        if (grant0 && !res0_valid_q) begin
            cnt0_d = cnt0_q + 3'd1;
        end else if (!grant0 && res0_valid_q) begin
            cnt0_d = cnt0_q - 3'd1;
        end

        cnt1_d = cnt1_q;
        if (grant1 && !res1_valid_q) begin
            cnt1_d = cnt1_q + 3'd1;
        end else if (!grant1 && res1_valid_q) begin
            cnt1_d = cnt1_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            pipe_vld_q   <= '0;
            pipe_tag_q   <= '0;
            sh_data_q    <= '0;
            sh_amt_q     <= '0;
            res0_valid_q <= 1'b0;
            res0_data_q  <= '0;
            res1_valid_q <= 1'b0;
            res1_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_tag_q   <= pipe_tag_d;
            sh_data_q    <= sh_data_d;
            sh_amt_q     <= sh_amt_d;
            res0_valid_q <= res0_valid_d;
            res0_data_q  <= res0_data_d;
            res1_valid_q <= res1_valid_d;
            res1_data_q  <= res1_data_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign sh_valid   = pipe_vld_q[0];
    assign sh_data    = sh_data_q;
    assign sh_amt     = sh_amt_q;
    assign res0_valid = res0_valid_q;
    assign res0_data  = res0_data_q;
    assign res1_valid = res1_valid_q;
    assign res1_data  = res1_data_q;
    assign idle       = (cnt0_q == 3'd0) && (cnt1_q == 3'd0);

endmodule
